m_decode_queue: RTL and testbench
=================================

# m_decode_queue

Buffered, parametrised instruction decoder for the multi-cycle MIPS core. It accepts fetched instructions over a valid/ready handshake and decodes each into an instruction ID plus class flags at write time. The decoded bundle is stored in a DEPTH-entry FIFO and presented to the control FSM over a second valid/ready handshake. It sits between the instruction fetch path and the main controller, and decouples fetch from execute.

## Interface

- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PC_W, 32, width of the PC tag carried with each instruction.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous queue clear (used on a taken branch or jump).
- in_valid  in  1  producer has an instruction.
- in_ready  out  1  queue can accept; equals !full.
- in_inst  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer takes the head entry.
- out_inst  out  32  head instruction word.
- out_pc  out  PC_W  head PC.
- out_id  out  5  decoded instruction ID (see Operation).
- out_class  out  5  class flags {Rtype, Itype, shift, MemAccess, branch}.
- out_illegal  out  1  head entry is unrecognised (see Configuration).
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Fields: op = inst[31:26], func = inst[5:0].
- Push condition: in_valid && in_ready. On push:
  - inst and pc are written to the tail slot.
  - id and class are written to the same slot, computed combinationally from in_inst.
- Pop condition: out_valid && out_ready. On pop, the head advances.
- Push and pop may happen in the same cycle. In that case count is unchanged. This is legal when full because in_ready is low, so no push can occur.
- out_id encoding, by op:
  - 0 = unrecognised.
  - 1 j (op 2), 2 jal (3), 3 beq (4), 4 bne (5).
  - 5 addi (8), 6 slti (10), 7 andi (12), 8 ori (13), 9 xori (14), 10 lui (15).
  - 11 lw (35), 12 sw (43).
- out_id encoding, for op 0 by func:
  - 13 sll (0), 14 srl (2), 15 jr (8), 16 jalr (9).
  - 17 add (32), 18 sub (34), 19 and (36), 20 or (37), 21 xor (38), 22 nor (39), 23 slt (42).
- Class flags:
  - Rtype: op 0 and 32 ≤ func ≤ 42.
  - Itype: 8 ≤ op ≤ 14.
  - shift: op 0 and func is 0 or 2.
  - MemAccess: op 35 or 43.
  - branch: op 4 or 5.
- An all-zero word decodes as sll (id 13, shift = 1).
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is tracked by the count register, not by comparing pointers.
- flush takes priority over push and pop. On the next edge, pointers and count go to 0 and any push or pop in that cycle is discarded. Storage contents are not cleared.

## Timing

- Reset (async assert, sync release):
  - count = 0, pointers = 0, all storage = 0.
  - out_valid = 0, in_ready = 1.
  - out_inst = 0, out_pc = 0, out_id = 0, out_class = 0, out_illegal = 0.
- Latency: an instruction pushed at edge N is visible with out_valid = 1 after edge N. There is no combinational fall-through from in_* to out_*.
- Output sources:
  - in_ready and out_valid derive only from count.
  - in_ready has no combinational path from out_ready.
  - out_inst, out_pc, out_id, out_class and out_illegal are driven from the head slot and are stable while out_valid is high and out_ready is low.
- Throughput: 1 instruction per cycle in steady state with concurrent push and pop.
- Full (count = DEPTH): in_ready = 0, and in_valid is ignored.
- Empty: out_valid = 0, and out_ready is ignored. Out data shows stale head-slot contents.
- rst_n asserted mid-operation: the queue empties immediately and in-flight entries are lost.

## Configuration

- Macro: DECODE_ILLEGAL_EN.
- Defined:
  - out_illegal = 1 when the head entry's id = 0, stored per entry at push time.
  - A pushed illegal word also sets a sticky internal flag that forces in_ready = 0.
  - The flag is cleared only by flush or reset. Fetch therefore stalls until the controller traps.
- Undefined:
  - out_illegal is tied to 0 and the sticky flag is absent.
  - Unrecognised words pass through with id = 0 and all class flags 0.

## Test plan

- Reset, then push 0x8C080004 (lw) with pc 0x100 → one cycle later out_valid = 1, out_id = 11, out_class = 00010, count = 1.
- With out_ready = 0 and DEPTH = 4:
  - Push 4 words → in_ready = 0 at count = 4.
  - A 5th push with in_valid = 1 is dropped.
  - Pop all 4 → words come out in order; out_valid = 0 after the 4th pop.
- Continuous in_valid and out_ready for 10 words across pointer wrap → count stays 1 and each word exits exactly one cycle after entry.
- Fill with 3 entries, assert flush together with a push → next cycle count = 0, out_valid = 0, in_ready = 1.
- With DECODE_ILLEGAL_EN, push 0xFC000000 → out_id = 0, out_illegal = 1, and in_ready stays 0 until flush.
- Without the macro, the same word gives out_illegal = 0 and in_ready stays 1.

Source files
------------

// File: rtl/m_decode_queue.sv
// Buffered MIPS instruction decoder: decodes at push time into a DEPTH-entry FIFO.
// Ports: clk, rst_n (async low), flush, in_valid/in_ready/in_inst/in_pc,
//        out_valid/out_ready/out_inst/out_pc/out_id/out_class/out_illegal, count.
// Optional feature macro: DECODE_ILLEGAL_EN (per-entry illegal flag + sticky fetch stall).
module m_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [4:0]                 out_id,
    output logic [4:0]                 out_class,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     inst_q  [DEPTH];
    logic [31:0]     inst_d  [DEPTH];
    logic [PC_W-1:0] pc_q    [DEPTH];
    logic [PC_W-1:0] pc_d    [DEPTH];
    logic [4:0]      id_q    [DEPTH];
    logic [4:0]      id_d    [DEPTH];
    logic [4:0]      class_q [DEPTH];
    logic [4:0]      class_d [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [5:0]      op;
    logic [5:0]      func;
    logic [4:0]      dec_id;
    logic [4:0]      dec_class;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign op   = in_inst[31:26];
    assign func = in_inst[5:0];

    always_comb begin
        dec_id = 5'd0;
        case (op)
            6'd2:  dec_id = 5'd1;
            6'd3:  dec_id = 5'd2;
            6'd4:  dec_id = 5'd3;
            6'd5:  dec_id = 5'd4;
            6'd8:  dec_id = 5'd5;
            6'd10: dec_id = 5'd6;
            6'd12: dec_id = 5'd7;
            6'd13: dec_id = 5'd8;
            6'd14: dec_id = 5'd9;
            6'd15: dec_id = 5'd10;
            6'd35: dec_id = 5'd11;
            6'd43: dec_id = 5'd12;
            6'd0: begin
                case (func)
                    6'd0:  dec_id = 5'd13;
                    6'd2:  dec_id = 5'd14;
                    6'd8:  dec_id = 5'd15;
                    6'd9:  dec_id = 5'd16;
                    6'd32: dec_id = 5'd17;
                    6'd34: dec_id = 5'd18;
                    6'd36: dec_id = 5'd19;
                    6'd37: dec_id = 5'd20;
                    6'd38: dec_id = 5'd21;
                    6'd39: dec_id = 5'd22;
                    6'd42: dec_id = 5'd23;
                    default: dec_id = 5'd0;
                endcase
            end
            default: dec_id = 5'd0;
        endcase
    end

    // Class flags are range-based on raw fields, independent of the id table.
    always_comb begin
        dec_class    = 5'd0;
        dec_class[4] = (op == 6'd0) && (func >= 6'd32) && (func <= 6'd42);
        dec_class[3] = (op >= 6'd8) && (op <= 6'd14);
        dec_class[2] = (op == 6'd0) && ((func == 6'd0) || (func == 6'd2));
        dec_class[1] = (op == 6'd35) || (op == 6'd43);
        dec_class[0] = (op == 6'd4) || (op == 6'd5);
    end

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign count     = count_q;

`ifdef DECODE_ILLEGAL_EN
    logic ill_q [DEPTH];
    logic ill_d [DEPTH];
    logic stall_q, stall_d;

    // Sticky stall holds fetch off after an illegal word until flush/reset.
    assign in_ready    = !full && !stall_q;
    assign out_illegal = ill_q[rd_ptr_q];
`else
    assign in_ready    = !full;
    assign out_illegal = 1'b0;
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        inst_d   = inst_q;
        pc_d     = pc_q;
        id_d     = id_q;
        class_d  = class_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
`ifdef DECODE_ILLEGAL_EN
        ill_d    = ill_q;
        stall_d  = stall_q;
`endif
        if (flush) begin
            // Storage is left intact; only bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
`ifdef DECODE_ILLEGAL_EN
            stall_d  = 1'b0;
`endif
        end else begin
            if (push) begin
                inst_d[wr_ptr_q]  = in_inst;
                pc_d[wr_ptr_q]    = in_pc;
                id_d[wr_ptr_q]    = dec_id;
                class_d[wr_ptr_q] = dec_class;
                wr_ptr_d          = wr_ptr_q + AW'(1);
`ifdef DECODE_ILLEGAL_EN
                ill_d[wr_ptr_q]   = (dec_id == 5'd0);
                if (dec_id == 5'd0) begin
                    stall_d = 1'b1;
                end
`endif
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]  <= '0;
                pc_q[i]    <= '0;
                id_q[i]    <= '0;
                class_q[i] <= '0;
`ifdef DECODE_ILLEGAL_EN
                ill_q[i]   <= 1'b0;
`endif
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef DECODE_ILLEGAL_EN
            stall_q  <= 1'b0;
`endif
        end else begin
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            id_q     <= id_d;
            class_q  <= class_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef DECODE_ILLEGAL_EN
            ill_q    <= ill_d;
            stall_q  <= stall_d;
`endif
        end
    end

    assign out_inst  = inst_q[rd_ptr_q];
    assign out_pc    = pc_q[rd_ptr_q];
    assign out_id    = id_q[rd_ptr_q];
    assign out_class = class_q[rd_ptr_q];

endmodule

// File: tb/tb_m_decode_queue.sv
// Directed bench for m_decode_queue (DEPTH=4, PC_W=32).
// Expected values are hand-derived from the decode tables.
module tb_m_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  out_id;
    logic [4:0]  out_class;
    logic        out_illegal;
    logic [2:0]  count;

    int n_cmp;
    int n_bad;

    m_decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_id      (out_id),
        .out_class   (out_class),
        .out_illegal (out_illegal),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_w   [4];
    logic [31:0] fill_id  [4];
    logic [31:0] fill_cls [4];
    logic [31:0] str_w    [10];
    logic [31:0] str_id   [10];
    logic [31:0] str_cls  [10];

    initial begin
        fill_w[0] = 32'h01095020; fill_id[0] = 17; fill_cls[0] = 32'b10000;
        fill_w[1] = 32'h11090003; fill_id[1] = 3;  fill_cls[1] = 32'b00001;
        fill_w[2] = 32'h21080001; fill_id[2] = 5;  fill_cls[2] = 32'b01000;
        fill_w[3] = 32'h00000000; fill_id[3] = 13; fill_cls[3] = 32'b00100;

        str_w[0] = 32'h08000010; str_id[0] = 1;  str_cls[0] = 32'b00000;
        str_w[1] = 32'h0C000010; str_id[1] = 2;  str_cls[1] = 32'b00000;
        str_w[2] = 32'h15090002; str_id[2] = 4;  str_cls[2] = 32'b00001;
        str_w[3] = 32'h29080005; str_id[3] = 6;  str_cls[3] = 32'b01000;
        str_w[4] = 32'h31080005; str_id[4] = 7;  str_cls[4] = 32'b01000;
        str_w[5] = 32'h35080005; str_id[5] = 8;  str_cls[5] = 32'b01000;
        str_w[6] = 32'h39080005; str_id[6] = 9;  str_cls[6] = 32'b01000;
        str_w[7] = 32'h3C080005; str_id[7] = 10; str_cls[7] = 32'b00000;
        str_w[8] = 32'hAC080004; str_id[8] = 12; str_cls[8] = 32'b00010;
        str_w[9] = 32'h00084042; str_id[9] = 14; str_cls[9] = 32'b00100;

        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (3) step();

        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_class", 32'(out_class), 0);
        chk("rst_out_illegal", 32'(out_illegal), 0);
        rst_n = 1'b1;
        step();

        // single lw
        in_valid = 1'b1;
        in_inst  = 32'h8C080004;
        in_pc    = 32'h100;
        step();
        in_valid = 1'b0;
        chk("lw_valid", 32'(out_valid), 1);
        chk("lw_id", 32'(out_id), 11);
        chk("lw_class", 32'(out_class), 32'b00010);
        chk("lw_count", 32'(count), 1);
        chk("lw_pc", out_pc, 32'h100);
        chk("lw_inst", out_inst, 32'h8C080004);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("lw_pop_valid", 32'(out_valid), 0);
        chk("lw_pop_count", 32'(count), 0);

        // fill to full
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = fill_w[i];
            in_pc    = 32'h200 + 32'(4 * i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("full_in_ready", 32'(in_ready), 0);
        in_inst = 32'h03E00008;
        in_pc   = 32'h300;
        step();
        in_valid = 1'b0;
        chk("drop_count", 32'(count), 4);

        // drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_inst", out_inst, fill_w[i]);
            chk("drain_pc", out_pc, 32'h200 + 32'(4 * i));
            chk("drain_id", 32'(out_id), fill_id[i]);
            chk("drain_class", 32'(out_class), fill_cls[i]);
            step();
        end
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_count", 32'(count), 0);

        // streaming across pointer wrap
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_inst = str_w[i];
            in_pc   = 32'h400 + 32'(4 * i);
            step();
            chk("str_count", 32'(count), 1);
            chk("str_inst", out_inst, str_w[i]);
            chk("str_id", 32'(out_id), str_id[i]);
            chk("str_class", 32'(out_class), str_cls[i]);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("str_end_count", 32'(count), 0);

        // flush beats a concurrent push
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = fill_w[i];
            in_pc   = 32'h500 + 32'(4 * i);
            step();
        end
        chk("pre_flush_count", 32'(count), 3);
        flush = 1'b1;
        in_inst = fill_w[3];
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);

        // unrecognised word
        in_valid = 1'b1;
        in_inst  = 32'hFC000000;
        in_pc    = 32'h600;
        step();
        in_valid = 1'b0;
        chk("ill_id", 32'(out_id), 0);
        chk("ill_class", 32'(out_class), 0);
        chk("ill_count", 32'(count), 1);
`ifdef DECODE_ILLEGAL_EN
        chk("ill_flag", 32'(out_illegal), 1);
        chk("ill_in_ready", 32'(in_ready), 0);
        step();
        chk("ill_in_ready_hold", 32'(in_ready), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ill_after_flush", 32'(in_ready), 1);
`else
        chk("ill_flag", 32'(out_illegal), 0);
        chk("ill_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ill_pop_count", 32'(count), 0);
`endif

        // async reset mid-operation
        in_valid = 1'b1;
        in_inst  = 32'h0000002A;
        in_pc    = 32'h700;
        step();
        chk("slt_id", 32'(out_id), 23);
        chk("slt_class", 32'(out_class), 32'b10000);
        step();
        in_valid = 1'b0;
        chk("mid_count", 32'(count), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_valid", 32'(out_valid), 0);
        chk("async_inst", out_inst, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
